// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if: config, serial stream and detect/status bundle for seq_detector_prog
interface seq_detector_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
);
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               in_bit;
   logic               detect;
   logic               armed;
   logic               cfg_err;
   logic [CNT_W-1:0]   match_count;

   modport master (
      output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
      input  detect, armed, cfg_err, match_count
   );

   modport slave (
      input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
      output detect, armed, cfg_err, match_count
   );
endinterface

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector; match counter built only with SEQ_DET_COUNT_EN
module seq_detector_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input logic               clk,
   input logic               reset,
   seq_detector_prog_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

   state_t             state_q, state_n;
   logic [MAX_LEN-1:0] hist_q, hist_n, pat_q, pat_n, shift, mask;
   logic [LEN_W-1:0]   len_q, len_n, fill_q, fill_n, fill_inc;
   logic               ovl_q, ovl_n, det_q, det_n, err_q, err_n;
   logic               legal, take, match;

   // candidate history/fill for an accepted bit and the masked pattern compare
   always_comb begin
      legal    = bus.cfg_len != '0 && bus.cfg_len <= LEN_W'(MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len_q);
      shift    = {hist_q[MAX_LEN-2:0], bus.in_bit};
      fill_inc = fill_q < len_q ? fill_q + 1'b1 : fill_q;
      take     = !bus.cfg_load && state_q != IDLE && bus.in_valid;
      match    = take && fill_inc >= len_q && ((shift ^ pat_q) & mask) == '0;
   end

   // next state: a config load overrides the stream, otherwise consume accepted bits
   always_comb begin
      state_n = state_q;
      hist_n  = hist_q;
      fill_n  = fill_q;
      pat_n   = pat_q;
      len_n   = len_q;
      ovl_n   = ovl_q;
      err_n   = err_q;
      det_n   = match;
      if (bus.cfg_load) begin
         state_n = legal ? FILL : IDLE;
         err_n   = !legal;
         if (legal) begin
            pat_n  = bus.cfg_pattern;
            len_n  = bus.cfg_len;
            ovl_n  = bus.cfg_overlap;
            hist_n = '0;
            fill_n = '0;
         end
      end else if (take) begin
         hist_n  = shift;
         fill_n  = (match && !ovl_q) ? '0 : fill_inc;
         state_n = ((match && !ovl_q) || fill_inc < len_q) ? FILL : HUNT;
      end
   end

   // state and config registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         det_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         hist_q  <= hist_n;
         fill_q  <= fill_n;
         pat_q   <= pat_n;
         len_q   <= len_n;
         ovl_q   <= ovl_n;
         det_q   <= det_n;
         err_q   <= err_n;
      end
   end

   assign bus.detect  = det_q;
   assign bus.armed   = state_q != IDLE;
   assign bus.cfg_err = err_q;

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_n;

   // saturating match count, cleared by any config load
   always_comb cnt_n = bus.cfg_load ? '0 : (match && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

   // counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_n;
   end

   assign bus.match_count = cnt_q;
`else
   assign bus.match_count = CNT_W'(0);
`endif
endmodule
